spi_bit_onehot_tracker: RTL and testbench

One-hot bit-position tracker for one SPI frame inside the SPI execution unit.
On a start request it loads a one-hot token and rotates it on every shift-enable pulse (one per SCLK sampling edge), so exactly one bit marks the current data-bit position.
It drives the one-hot-to-binary encoder directly downstream, which derives the bit index for the shift/mux logic, and it flags last bit and frame completion to the transfer controller.

---
 rtl/spi_exe_pkg.sv | 12 +
 rtl/spi_bit_onehot_tracker.sv | 107 ++++++++++
 tb/tb_spi_bit_onehot_tracker.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/spi_exe_pkg.sv
// Shared SPI execution unit definitions: bit-tracker state encoding and default frame length.
package spi_exe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } spi_bit_state_t;

  localparam int SPI_FRAME_LEN = 8;

endpackage

// File: rtl/spi_bit_onehot_tracker.sv
// One-hot bit-position tracker for one SPI frame; every output is a flop or a flop decode.
// Build option: define SPI_BIT_MSB_FIRST_EN to start at bit LEN-1 and rotate toward bit 0.
module spi_bit_onehot_tracker
  import spi_exe_pkg::*;
#(
  parameter int LEN = SPI_FRAME_LEN
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic           i_shift_en,
  input  logic           i_abort,
  output logic [LEN-1:0] o_onehot,
  output logic           o_busy,
  output logic           o_last,
  output logic           o_done,
  output logic           o_err
);

  localparam logic [LEN-1:0] LSB_POS = {{(LEN-1){1'b0}}, 1'b1};
  localparam logic [LEN-1:0] MSB_POS = {1'b1, {(LEN-1){1'b0}}};

`ifdef SPI_BIT_MSB_FIRST_EN
  localparam logic [LEN-1:0] FIRST_POS = MSB_POS;
  localparam logic [LEN-1:0] LAST_POS  = LSB_POS;
`else
  localparam logic [LEN-1:0] FIRST_POS = LSB_POS;
  localparam logic [LEN-1:0] LAST_POS  = MSB_POS;
`endif

  spi_bit_state_t state_q, state_d;
  logic [LEN-1:0] token_q, token_d;
  logic           last_q, last_d;
  logic           err_q, err_set;

  function automatic logic [LEN-1:0] rotate(input logic [LEN-1:0] v);
`ifdef SPI_BIT_MSB_FIRST_EN
    return {v[0], v[LEN-1:1]};
`else
    return {v[LEN-2:0], v[LEN-1]};
`endif
  endfunction

  // Integrity check runs independently of abort so a corrupted token is always reported.
  assign err_set = (state_q == RUN) && !$onehot(token_q);

  always_comb begin
    state_d = state_q;
    token_d = '0;
    if (i_abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            state_d = RUN;
            token_d = FIRST_POS;
          end
        end
        RUN: begin
          if (err_set) begin
            state_d = IDLE;
          end else if (i_shift_en) begin
            if (token_q == LAST_POS) begin
              state_d = DONE;
            end else begin
              token_d = rotate(token_q);
            end
          end else begin
            token_d = token_q;
          end
        end
        DONE: begin
          if (i_start) begin
            state_d = RUN;
            token_d = FIRST_POS;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    last_d = (state_d == RUN) && (token_d == LAST_POS);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      token_q <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      token_q <= token_d;
      last_q  <= last_d;
      if (err_set) err_q <= 1'b1;
    end
  end

  assign o_onehot = token_q;
  assign o_busy   = (state_q == RUN);
  assign o_last   = last_q;
  assign o_done   = (state_q == DONE);
  assign o_err    = err_q;

endmodule

// File: tb/tb_spi_bit_onehot_tracker.sv
// Table-driven, hand-sequenced and randomized checks of spi_bit_onehot_tracker against a position-count model.
module tb_spi_bit_onehot_tracker;

  localparam int LEN = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start, shift, abort;
  logic [LEN-1:0] onehot;
  logic           busy, last, done, err;

  int tests = 0;
  int fails = 0;

  spi_bit_onehot_tracker #(.LEN(LEN)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_shift_en (shift),
    .i_abort    (abort),
    .o_onehot   (onehot),
    .o_busy     (busy),
    .o_last     (last),
    .o_done     (done),
    .o_err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic start;
    logic shift;
    logic abort;
    int   pos;
    logic busy;
    logic last;
    logic done;
  } vec_t;

  vec_t tbl[$];

  // pos counts data bits sent so far in the frame; -1 means no token.
  function automatic logic [LEN-1:0] pos_mask(input int pos);
    logic [LEN-1:0] m;
    m = '0;
    if (pos >= 0) begin
`ifdef SPI_BIT_MSB_FIRST_EN
      m[LEN-1-pos] = 1'b1;
`else
      m[pos] = 1'b1;
`endif
    end
    return m;
  endfunction

  task automatic add(input logic s, input logic sh, input logic ab, input int pos,
                     input logic b, input logic l, input logic d);
    vec_t v;
    v.start = s; v.shift = sh; v.abort = ab; v.pos = pos;
    v.busy = b; v.last = l; v.done = d;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [LEN+3:0] got, input logic [LEN+3:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got onehot/busy/last/done/err=%h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic [LEN+3:0] outs();
    return {onehot, busy, last, done, err};
  endfunction

  task automatic step(input logic s, input logic sh, input logic ab);
    @(negedge clk);
    start = s; shift = sh; abort = ab;
    @(posedge clk);
    #1;
  endtask

  // Reference model state
  int  m_running, m_pos, m_done;
  logic m_err;

  task automatic model_step(input logic s, input logic sh, input logic ab);
    int nd;
    nd = 0;
    if (ab) begin
      m_running = 0;
    end else if (m_running != 0) begin
      if (sh) begin
        if (m_pos == LEN - 1) begin
          m_running = 0;
          nd = 1;
        end else begin
          m_pos++;
        end
      end
    end else if (s) begin
      m_running = 1;
      m_pos = 0;
    end
    m_done = nd;
  endtask

  function automatic logic [LEN+3:0] model_outs();
    logic [LEN-1:0] oh;
    oh = (m_running != 0) ? pos_mask(m_pos) : '0;
    return {oh, (m_running != 0), (m_running != 0) && (m_pos == LEN - 1), (m_done != 0), m_err};
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; shift = 1'b0; abort = 1'b0;
    #2;
    check("reset_state", outs(), '0);
    @(negedge clk);
    rst = 1'b0;

    // start+shift in idle, full frame, start on the done cycle
    add(1, 1, 0, 0, 1, 0, 0);
    for (int i = 1; i < LEN; i++) add(0, 1, 0, i, 1, (i == LEN - 1), 0);
    add(0, 1, 0, -1, 0, 0, 1);
    add(1, 0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) add(0, 1, 0, i, 1, 0, 0);
    // abort after four shifts, then start+abort in idle
    add(0, 1, 1, -1, 0, 0, 0);
    add(1, 0, 1, -1, 0, 0, 0);
    add(0, 0, 0, -1, 0, 0, 0);
    add(0, 1, 0, -1, 0, 0, 0);
    // start ignored during RUN
    add(1, 0, 0, 0, 1, 0, 0);
    add(1, 1, 0, 1, 1, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 1, -1, 0, 0, 0);
    // frame ending into idle
    add(1, 0, 0, 0, 1, 0, 0);
    for (int i = 1; i < LEN; i++) add(0, 1, 0, i, 1, (i == LEN - 1), 0);
    add(0, 1, 0, -1, 0, 0, 1);
    add(0, 1, 0, -1, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].start, tbl[i].shift, tbl[i].abort);
      check($sformatf("vec%0d", i), outs(),
            {pos_mask(tbl[i].pos), tbl[i].busy, tbl[i].last, tbl[i].done, 1'b0});
    end

    // Corrupt the token mid-frame: error must latch and the frame must drop.
    step(1, 0, 0);
    step(0, 1, 0);
    @(negedge clk);
    start = 1'b0; shift = 1'b0;
    force dut.token_q = 8'h18;
    #1;
    release dut.token_q;
    @(posedge clk);
    #1;
    check("err_set", outs(), {8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
    step(1, 0, 0);
    check("err_sticky_run", outs(), {pos_mask(0), 1'b1, 1'b0, 1'b0, 1'b1});
    step(0, 0, 1);
    check("err_sticky_abort", outs(), {8'h00, 1'b0, 1'b0, 1'b0, 1'b1});

    // Async reset mid-frame after three shifts, no clock edge needed.
    step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    check("pre_reset_pos3", outs(), {pos_mask(3), 1'b1, 1'b0, 1'b0, 1'b1});
    rst = 1'b1;
    #1;
    check("async_reset", outs(), '0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0; shift = 1'b0; abort = 1'b0;

    m_running = 0; m_pos = 0; m_done = 0; m_err = 1'b0;
    for (int i = 0; i < 600; i++) begin
      logic s, sh, ab;
      s  = ($urandom_range(0, 3) == 0);
      sh = ($urandom_range(0, 1) == 1);
      ab = ($urandom_range(0, 24) == 0);
      step(s, sh, ab);
      model_step(s, sh, ab);
      check($sformatf("rand%0d", i), outs(), model_outs());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
